pulse_spacer: RTL and testbench

Fast-domain front end for the toggle-based fast-to-slow pulse synchronizer. It accepts single-cycle event pulses on i_fast_clock at any rate, counts pending events, and re-emits them one at a time. Consecutive output pulses are separated by at least MIN_GAP fast cycles, so each one survives the 3-flop slow-domain capture without merging. o_fast_pulse drives the synchronizer's i_fast_pulse directly.

---
 rtl/ucie_sync_pkg.sv | 21 ++
 rtl/pulse_spacer_if.sv | 40 ++++
 rtl/pulse_spacer_gap_cnt.sv | 31 +++
 rtl/pulse_spacer.sv | 145 ++++++++++++++
 tb/tb_pulse_spacer.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/ucie_sync_pkg.sv
// Shared types and constants for the fast-to-slow pulse sync path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ucie_sync_pkg;

    // Sequencing state shared by the sync-path front ends.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EMIT = 2'b01,
        GAP  = 2'b10
    } sync_state_e;

    // Width of the optional saturating drop counter.
    localparam int DROP_CNT_W = 16;

    // A spacing below 2 would let two pulses sit on adjacent cycles.
    function automatic bit min_gap_legal(input int min_gap);
        return (min_gap >= 2);
    endfunction

endpackage

// File: rtl/pulse_spacer_if.sv
// Event/flush inputs and spaced-pulse status outputs of pulse_spacer.
// Latency: n/a (wires only).
// Backpressure: none; events arrive at any rate, excess is counted as overflow.
//
// master : event source (drives i_event/i_flush, observes status)
// slave  : pulse_spacer
// o_drop_cnt exists only when PULSE_SPACER_STATS_EN is defined.
interface pulse_spacer_if #(
    parameter int CNT_W = 4
) ();
    import ucie_sync_pkg::*;

    logic             i_event;
    logic             i_flush;
    logic             o_fast_pulse;
    logic [CNT_W-1:0] o_pending;
    logic             o_busy;
    logic             o_overflow;
`ifdef PULSE_SPACER_STATS_EN
    logic [DROP_CNT_W-1:0] o_drop_cnt;

    modport master (
        output i_event, i_flush,
        input  o_fast_pulse, o_pending, o_busy, o_overflow, o_drop_cnt
    );
    modport slave (
        input  i_event, i_flush,
        output o_fast_pulse, o_pending, o_busy, o_overflow, o_drop_cnt
    );
`else
    modport master (
        output i_event, i_flush,
        input  o_fast_pulse, o_pending, o_busy, o_overflow
    );
    modport slave (
        input  i_event, i_flush,
        output o_fast_pulse, o_pending, o_busy, o_overflow
    );
`endif
endinterface

// File: rtl/pulse_spacer_gap_cnt.sv
// Loadable down-counter that flags its terminal count (zero).
// Latency: load takes effect on the next edge; tc is combinational from the count.
// Backpressure: none; en simply holds the count when low.
//
// Ports: i_fast_clock/i_fast_rst_n clock and async active-low reset,
//        load/load_val parallel load, en count enable, tc count == 0.
module pulse_spacer_gap_cnt #(
    parameter int W = 3
) (
    input  logic         i_fast_clock,
    input  logic         i_fast_rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         tc
);
    logic [W-1:0] cnt_q;

    always_ff @(posedge i_fast_clock or negedge i_fast_rst_n) begin
        if (!i_fast_rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign tc = (cnt_q == '0);

endmodule

// File: rtl/pulse_spacer.sv
// Counts incoming event pulses and re-emits them one at a time, MIN_GAP cycles apart.
// Latency: event at edge k from idle -> o_fast_pulse high in the cycle after edge k+1.
// Backpressure: none; backlog saturates at 2^CNT_W-1, extra events set sticky o_overflow.
//
// Ports: i_fast_clock, i_fast_rst_n (async, active-low), bus (pulse_spacer_if.slave):
//        i_event, i_flush in; o_fast_pulse, o_pending, o_busy, o_overflow out.
// Optional: PULSE_SPACER_STATS_EN adds bus.o_drop_cnt (saturating count of dropped events).
module pulse_spacer
    import ucie_sync_pkg::*;
#(
    parameter int MIN_GAP = 8,
    parameter int CNT_W   = 4
) (
    input  logic           i_fast_clock,
    input  logic           i_fast_rst_n,
    pulse_spacer_if.slave  bus
);
    if (!min_gap_legal(MIN_GAP) || (CNT_W < 1)) begin : g_param_err
        $fatal(1, "pulse_spacer: MIN_GAP must be >= 2 and CNT_W >= 1");
    end

    // The GAP state lasts MIN_GAP-1 cycles: the counter is loaded with MIN_GAP-2
    // and GAP ends on the cycle it reads zero.
    localparam int                 GAP_W    = (MIN_GAP > 2) ? $clog2(MIN_GAP - 1) : 1;
    localparam logic [GAP_W-1:0]   GAP_LOAD = GAP_W'(MIN_GAP - 2);
    localparam logic [CNT_W-1:0]   PEND_MAX = '1;

    sync_state_e       state_q;
    logic [CNT_W-1:0]  pend_q;
    logic [CNT_W-1:0]  pend_d;
    logic              ovf_q;
    logic              ovf_d;
    logic              pulse_q;
    logic              busy_q;
    logic              gap_tc;
    logic              inc;
    logic              dec;
    logic              drop;
    logic              go_emit;
    logic              stay_busy;

    pulse_spacer_gap_cnt #(
        .W(GAP_W)
    ) u_gap_cnt (
        .i_fast_clock (i_fast_clock),
        .i_fast_rst_n (i_fast_rst_n),
        .load         (state_q == EMIT),
        .load_val     (GAP_LOAD),
        .en           (state_q == GAP),
        .tc           (gap_tc)
    );

    // Pending-event counter. Flush wins over everything, and a flushed event
    // is discarded rather than treated as an overflow.
    always_comb begin
        inc    = bus.i_event && !bus.i_flush;
        dec    = (state_q == EMIT) && (pend_q != '0);
        drop   = inc && !dec && (pend_q == PEND_MAX);
        pend_d = pend_q;
        ovf_d  = ovf_q;
        if (bus.i_flush) begin
            pend_d = '0;
            ovf_d  = 1'b0;
        end else begin
            if (inc && !dec && !drop) begin
                pend_d = pend_q + 1'b1;
            end else if (dec && !inc) begin
                pend_d = pend_q - 1'b1;
            end
            if (drop) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_fast_clock or negedge i_fast_rst_n) begin
        if (!i_fast_rst_n) begin
            pend_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
        end
    end

    // From IDLE the registered count decides (adds one cycle of latency); at
    // the end of a gap the count including this cycle's event decides, which
    // keeps back-to-back pulses exactly MIN_GAP apart.
    always_comb begin
        go_emit   = ((state_q == IDLE) && (pend_q != '0) && !bus.i_flush) ||
                    ((state_q == GAP) && gap_tc && (pend_d != '0));
        stay_busy = (state_q == EMIT) || ((state_q == GAP) && !gap_tc);
    end

    always_ff @(posedge i_fast_clock or negedge i_fast_rst_n) begin
        if (!i_fast_rst_n) begin
            state_q <= IDLE;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            pulse_q <= go_emit;
            busy_q  <= go_emit || stay_busy || (pend_d != '0);
            case (state_q)
                IDLE: begin
                    if (go_emit) begin
                        state_q <= EMIT;
                    end
                end
                EMIT: begin
                    state_q <= GAP;
                end
                GAP: begin
                    if (gap_tc) begin
                        state_q <= go_emit ? EMIT : IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_fast_pulse = pulse_q;
    assign bus.o_pending    = pend_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_overflow   = ovf_q;

`ifdef PULSE_SPACER_STATS_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q;

    always_ff @(posedge i_fast_clock or negedge i_fast_rst_n) begin
        if (!i_fast_rst_n) begin
            drop_cnt_q <= '0;
        end else if (bus.i_flush) begin
            drop_cnt_q <= '0;
        end else if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end

    assign bus.o_drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_pulse_spacer.sv
// Self-checking bench for pulse_spacer against a time-based reference model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_pulse_spacer;
    localparam int MIN_GAP = 8;
    localparam int CNT_W   = 4;
    localparam int PMAX    = (1 << CNT_W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pulse_spacer_if #(.CNT_W(CNT_W)) bus ();

    pulse_spacer #(
        .MIN_GAP (MIN_GAP),
        .CNT_W   (CNT_W)
    ) dut (
        .i_fast_clock (clk),
        .i_fast_rst_n (rst_n),
        .bus          (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: edge index, edge of the last emitted pulse, backlog.
    // A pulse may only start MIN_GAP edges after the previous one; the
    // decrement lands one edge after the pulse edge.
    int m_n;
    int m_lp;
    int m_pend;
    int m_drop;
    bit m_ovf;
    bit m_pulse;
    bit m_busy;

    // Observation helpers.
    int cyc;
    int pulse_total;
    int pend_peak;
    int first_p;
    int last_p;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_n = 0; m_lp = -1000; m_pend = 0; m_drop = 0;
        m_ovf = 0; m_pulse = 0; m_busy = 0;
    endtask

    task automatic model_edge(input bit ev, input bit fl);
        int pa;
        bit dec;
        bit fire;
        dec  = (m_n == m_lp + 1) && (m_pend != 0);
        fire = 0;
        if (fl) begin
            pa = 0; m_ovf = 0; m_drop = 0;
        end else if (ev && !dec) begin
            if (m_pend == PMAX) begin
                pa = m_pend; m_ovf = 1;
                if (m_drop < 65535) m_drop++;
            end else begin
                pa = m_pend + 1;
            end
        end else if (dec && !ev) begin
            pa = m_pend - 1;
        end else begin
            pa = m_pend;
        end
        if (m_n == m_lp + MIN_GAP) fire = (pa != 0);
        else if (m_n > m_lp + MIN_GAP) fire = (m_pend != 0) && !fl;
        if (fire) m_lp = m_n;
        m_pend  = pa;
        m_pulse = fire;
        m_busy  = (pa != 0) || (m_n < m_lp + MIN_GAP);
        m_n++;
    endtask

    // One clock: drive inputs, let the edge happen, then compare at the negedge.
    task automatic step(input bit ev, input bit fl);
        bus.i_event = ev;
        bus.i_flush = fl;
        @(posedge clk);
        model_edge(ev, fl);
        @(negedge clk);
        cyc++;
        check("pulse",    bus.o_fast_pulse, m_pulse);
        check("pending",  bus.o_pending,    m_pend);
        check("busy",     bus.o_busy,       m_busy);
        check("overflow", bus.o_overflow,   m_ovf);
`ifdef PULSE_SPACER_STATS_EN
        check("drop_cnt", bus.o_drop_cnt,   m_drop);
`endif
        if (bus.o_fast_pulse) begin
            pulse_total++;
            if (first_p < 0) first_p = cyc;
            last_p = cyc;
        end
        if (int'(bus.o_pending) > pend_peak) pend_peak = int'(bus.o_pending);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 400 && bus.o_busy; i++) step(0, 0);
        check({name, "_drained"}, bus.o_busy, 0);
    endtask

    task automatic single_event(input string name);
        repeat (10) step(0, 0);
        step(1, 0);                                       // edge k
        check({name, "_pend_k"},   bus.o_pending, 1);
        check({name, "_pulse_k"},  bus.o_fast_pulse, 0);
        check({name, "_busy_k"},   bus.o_busy, 1);
        step(0, 0);                                       // edge k+1
        check({name, "_pulse_k1"}, bus.o_fast_pulse, 1);
        step(0, 0);                                       // edge k+2
        check({name, "_pulse_k2"}, bus.o_fast_pulse, 0);
        check({name, "_pend_k2"},  bus.o_pending, 0);
        repeat (6) step(0, 0);                            // edge k+8
        check({name, "_busy_k8"},  bus.o_busy, 1);
        step(0, 0);                                       // edge k+9: 8 cycles after pulse
        check({name, "_busy_k9"},  bus.o_busy, 0);
    endtask

    initial begin
        int pt0;
        int thr;
        bus.i_event = 1'b0;
        bus.i_flush = 1'b0;
        cyc = 0; pulse_total = 0; pend_peak = 0; first_p = -1; last_p = -1;
        model_reset();

        // Reset values
        #1;
        check("rst_pulse",    bus.o_fast_pulse, 0);
        check("rst_pending",  bus.o_pending, 0);
        check("rst_busy",     bus.o_busy, 0);
        check("rst_overflow", bus.o_overflow, 0);
`ifdef PULSE_SPACER_STATS_EN
        check("rst_drop_cnt", bus.o_drop_cnt, 0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // 1. Single event
        single_event("t1");

        // 2. Burst of 5: pulses 8 apart (4 gaps -> span 32), peak backlog 4
        pt0 = pulse_total; pend_peak = 0; first_p = -1;
        repeat (5) step(1, 0);
        drain("t2");
        check("t2_pulses",   pulse_total - pt0, 5);
        check("t2_span",     last_p - first_p, 4 * MIN_GAP);
        check("t2_peak",     pend_peak, 4);
        check("t2_overflow", bus.o_overflow, 0);

        // 3. Saturation: 20 events from idle. Decrements at edges 2, 10, 18
        // absorb three events; drops happen at edges 17 and 19 -> 18 accepted.
        pt0 = pulse_total; pend_peak = 0;
        repeat (20) step(1, 0);
        check("t3_peak",     pend_peak, PMAX);
        check("t3_overflow", bus.o_overflow, 1);
`ifdef PULSE_SPACER_STATS_EN
        check("t3_drop_cnt", bus.o_drop_cnt, 2);
`endif
        drain("t3");
        check("t3_pulses",   pulse_total - pt0, 18);
        check("t3_ovf_sticky", bus.o_overflow, 1);

        // 4. Flush mid-gap with backlog 6 and a coincident event
        repeat (7) step(1, 0);
        check("t4_backlog", bus.o_pending, 6);
        for (int i = 0; i < 20 && !bus.o_fast_pulse; i++) step(0, 0);
        check("t4_pulse_seen", bus.o_fast_pulse, 1);
        repeat (3) step(0, 0);
        step(1, 1);
        check("t4_pend_flushed", bus.o_pending, 0);
        check("t4_ovf_cleared",  bus.o_overflow, 0);
        check("t4_busy_in_gap",  bus.o_busy, 1);
`ifdef PULSE_SPACER_STATS_EN
        check("t4_drop_cleared", bus.o_drop_cnt, 0);
`endif
        pt0 = pulse_total;
        repeat (20) step(0, 0);
        check("t4_no_pulses", pulse_total - pt0, 0);
        check("t4_idle",      bus.o_busy, 0);

        // 6. Event coinciding with the EMIT decrement at max backlog
        for (int i = 0; i < 40 && bus.o_pending != PMAX; i++) step(1, 0);
        check("t6_full", bus.o_pending, PMAX);
        for (int i = 0; i < 20 && !bus.o_fast_pulse; i++) step(0, 0);
        check("t6_emit", bus.o_fast_pulse, 1);
        step(1, 0);
        check("t6_pending", bus.o_pending, PMAX);
        check("t6_overflow", bus.o_overflow, 0);
        drain("t6");

        // 5. Async reset while o_fast_pulse is high
        repeat (3) step(1, 0);
        for (int i = 0; i < 20 && !bus.o_fast_pulse; i++) step(0, 0);
        check("t5_pulse_seen", bus.o_fast_pulse, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_pulse",    bus.o_fast_pulse, 0);
        check("t5_pending",  bus.o_pending, 0);
        check("t5_busy",     bus.o_busy, 0);
        check("t5_overflow", bus.o_overflow, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        single_event("t5r");

        // Randomized traffic with varying load and occasional flushes
        for (int seg = 0; seg < 20; seg++) begin
            thr = $urandom_range(0, 100);
            for (int i = 0; i < 200; i++) begin
                step(($urandom_range(0, 99) < thr) ? 1'b1 : 1'b0,
                     ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0);
            end
        end
        step(0, 1);
        drain("rand");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
